// File: rtl/sysid_pkg.sv
// Shared types for the system-ID boot verifier: FSM state encoding and
// the two Avalon word addresses of the sysid slave.
package sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ID_REQ  = 3'd1,
        ST_ID_WAIT = 3'd2,
        ST_TS_REQ  = 3'd3,
        ST_TS_WAIT = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_FAIL    = 3'd7
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_timeout_cnt.sv
// Per-attempt cycle counter with a terminal flag, plus the retry counter
// for the current address phase. Both saturate instead of wrapping.
module sysid_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int MAX_RETRIES    = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic retry_clear,
    input  logic retry_inc,
    output logic terminal,
    output logic retry_exhausted
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic [CW-1:0] cnt;
    logic [RW-1:0] retries;

    assign terminal        = (cnt == CW'(TIMEOUT_CYCLES));
    assign retry_exhausted = (retries == RW'(MAX_RETRIES));

    // clear wins over enable so a retry restarts the attempt at zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !terminal) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retries <= '0;
        end else if (retry_clear) begin
            retries <= '0;
        end else if (retry_inc && !retry_exhausted) begin
            retries <= retries + RW'(1);
        end
    end

endmodule

// File: rtl/sysid_verify_ctrl.sv
// Boot-time sequencer: reads the sysid ID word then timestamp over Avalon-MM,
// compares them with the build-time values and reports pass/fail as levels.
module sysid_verify_ctrl
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1417958911,
    parameter int          TIMEOUT_CYCLES = 1023,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rescan,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        err_timeout,
    output logic        err_id,
    output logic        err_ts,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [2:0]  dbg_state
);

    // Handshake: avm_read is held with a fixed address while waitrequest is
    // high and the request is accepted on the first cycle waitrequest is low.
    // readdata is taken only on readdatavalid, which may coincide with the
    // accept cycle or arrive any number of cycles later within the timeout.

    sysid_state_e state, next_state;

    logic in_id, in_ts, in_req, captured;
    logic cnt_clear, cnt_en, retry_clear, retry_inc;
    logic cap_id, cap_ts, check_en, flag_clear, set_timeout;
    logic cnt_terminal, retry_exhausted;

    assign in_id  = (state == ST_ID_REQ) || (state == ST_ID_WAIT);
    assign in_ts  = (state == ST_TS_REQ) || (state == ST_TS_WAIT);
    assign in_req = (state == ST_ID_REQ) || (state == ST_TS_REQ);
    // in a request state the data only counts once the slave has accepted
    assign captured = avm_readdatavalid && (!in_req || !avm_waitrequest);

    sysid_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) u_timeout (
        .clock           (clock),
        .reset           (reset),
        .clear           (cnt_clear),
        .enable          (cnt_en),
        .retry_clear     (retry_clear),
        .retry_inc       (retry_inc),
        .terminal        (cnt_terminal),
        .retry_exhausted (retry_exhausted)
    );

    always_comb begin
        next_state  = state;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        retry_clear = 1'b0;
        retry_inc   = 1'b0;
        cap_id      = 1'b0;
        cap_ts      = 1'b0;
        check_en    = 1'b0;
        flag_clear  = 1'b0;
        set_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                next_state  = ST_ID_REQ;
                cnt_clear   = 1'b1;
                retry_clear = 1'b1;
            end
            ST_ID_REQ, ST_ID_WAIT, ST_TS_REQ, ST_TS_WAIT: begin
                cnt_en = 1'b1;
                if (captured) begin
                    cap_id      = in_id;
                    cap_ts      = in_ts;
                    next_state  = in_id ? ST_TS_REQ : ST_CHECK;
                    cnt_clear   = 1'b1;
                    retry_clear = 1'b1;
                end else if (cnt_terminal) begin
                    if (!retry_exhausted) begin
                        retry_inc  = 1'b1;
                        cnt_clear  = 1'b1;
                        next_state = in_id ? ST_ID_REQ : ST_TS_REQ;
                    end else begin
                        set_timeout = 1'b1;
                        next_state  = ST_FAIL;
                    end
                end else if (in_req && !avm_waitrequest) begin
                    next_state = in_id ? ST_ID_WAIT : ST_TS_WAIT;
                end
            end
            ST_CHECK: begin
                check_en   = 1'b1;
                next_state = ((id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS))
                             ? ST_DONE : ST_FAIL;
            end
            ST_DONE, ST_FAIL: begin
                if (rescan) begin
                    flag_clear  = 1'b1;
                    next_state  = ST_ID_REQ;
                    cnt_clear   = 1'b1;
                    retry_clear = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            id_value    <= '0;
            ts_value    <= '0;
            pass        <= 1'b0;
            err_timeout <= 1'b0;
            err_id      <= 1'b0;
            err_ts      <= 1'b0;
        end else begin
            state <= next_state;
            if (cap_id) id_value <= avm_readdata;
            if (cap_ts) ts_value <= avm_readdata;
            if (flag_clear) begin
                pass        <= 1'b0;
                err_timeout <= 1'b0;
                err_id      <= 1'b0;
                err_ts      <= 1'b0;
            end
            if (set_timeout) err_timeout <= 1'b1;
            if (check_en) begin
                err_id <= (id_value != EXPECTED_ID);
                err_ts <= (ts_value != EXPECTED_TS);
                pass   <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
            end
        end
    end

    // decoded from the async-reset state register, so reset drops the read at once
    assign avm_read    = in_req;
    assign avm_address = in_ts ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign busy        = in_id || in_ts || (state == ST_CHECK);
    assign done        = (state == ST_DONE) || (state == ST_FAIL);
    assign dbg_state   = state;

endmodule

// File: tb/tb_sysid_verify_ctrl.sv
// Bench for sysid_verify_ctrl: reactive Avalon sysid slave, outcome model
// with an expected queue, per-cycle compare process and directed scenarios.
module tb_sysid_verify_ctrl;

    localparam logic [31:0] EXP_ID  = 32'd0;
    localparam logic [31:0] EXP_TS  = 32'd1417958911;
    localparam int          TMO     = 15;
    localparam int          RETRIES = 2;
    localparam int          W       = 68;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rescan = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy, done, pass, err_timeout, err_id, err_ts;
    logic [31:0] id_value, ts_value;
    logic [2:0]  dbg_state;

    sysid_verify_ctrl #(
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES    (RETRIES)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .rescan            (rescan),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .err_timeout       (err_timeout),
        .err_id            (err_id),
        .err_ts            (err_ts),
        .id_value          (id_value),
        .ts_value          (ts_value),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, state %0d", dbg_state);
        $fatal(1, "watchdog expired");
    end

    // ---------------- slave configuration (written by main only) ----------------
    int          cfg_ws   = 0;
    int          cfg_lat  = 0;
    logic        cfg_mute = 1'b0;
    logic [31:0] cfg_id   = EXP_ID;
    logic [31:0] cfg_ts   = EXP_TS;
    logic        spur_en  = 1'b0;

    // ---------------- reactive sysid slave ----------------
    initial begin : slave
        int          wait_left;
        int          pend_cnt;
        logic        req_open;
        logic [31:0] pend_data;
        wait_left = 0;
        pend_cnt  = 0;
        req_open  = 1'b0;
        pend_data = '0;
        forever begin
            @(posedge clock);
            #1;
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
            if (reset) begin
                pend_cnt          = 0;
                req_open          = 1'b0;
                avm_waitrequest   = 1'b0;
                avm_readdatavalid = spur_en;
                avm_readdata      = 32'hDEAD_BEEF;
            end else begin
                avm_waitrequest = 1'b0;
                if (pend_cnt > 0) begin
                    pend_cnt = pend_cnt - 1;
                    if (pend_cnt == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = pend_data;
                    end
                end
                if (avm_read) begin
                    if (!req_open) begin
                        req_open  = 1'b1;
                        wait_left = cfg_ws;
                    end
                    if (wait_left > 0) begin
                        avm_waitrequest = 1'b1;
                        wait_left       = wait_left - 1;
                    end else begin
                        req_open = 1'b0;
                        if (!cfg_mute) begin
                            if (cfg_lat == 0) begin
                                avm_readdatavalid = 1'b1;
                                avm_readdata      = avm_address ? cfg_ts : cfg_id;
                            end else begin
                                pend_cnt  = cfg_lat;
                                pend_data = avm_address ? cfg_ts : cfg_id;
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- scoreboard: expected outcome per scan ----------------
    // entry = {err_timeout, err_ts, err_id, pass, id_value, ts_value}
    logic [W-1:0] exp_q[$];
    logic [31:0]  m_last_id = '0;
    logic [31:0]  m_last_ts = '0;

    task automatic push_expect();
        if (cfg_mute) begin
            exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, m_last_id, m_last_ts});
        end else begin
            m_last_id = cfg_id;
            m_last_ts = cfg_ts;
            exp_q.push_back({1'b0, cfg_ts != EXP_TS, cfg_id != EXP_ID,
                             (cfg_id == EXP_ID) && (cfg_ts == EXP_TS), cfg_id, cfg_ts});
        end
    endtask

    // ---------------- compare process (every cycle) ----------------
    int cmp_n     = 0;
    int cmp_fail  = 0;
    int exp_idx   = 0;
    int rd_hi[2]  = '{0, 0};
    int accept[2] = '{0, 0};

    initial begin : compare
        logic         done_prev;
        logic         have_cur;
        logic [W-1:0] cur;
        logic [W-1:0] act;
        done_prev = 1'b0;
        have_cur  = 1'b0;
        cur       = '0;
        forever begin
            @(negedge clock);
            act = {err_timeout, err_ts, err_id, pass, id_value, ts_value};
            if (reset) begin
                cmp_n++;
                if ({avm_read, avm_address, busy, done} != 4'b0 || act != '0) begin
                    cmp_fail++;
                    $display("FAIL reset_outputs: got rd=%b addr=%b busy=%b done=%b flags/values=%h required all zero",
                             avm_read, avm_address, busy, done, act);
                end
                done_prev = 1'b0;
            end else begin
                if (avm_read) rd_hi[avm_address]++;
                if (avm_read && !avm_waitrequest) accept[avm_address]++;
                cmp_n++;
                if ((busy && done) || (avm_read && !busy)) begin
                    cmp_fail++;
                    $display("FAIL status_consistency: got busy=%b done=%b rd=%b required busy xor done, rd only while busy",
                             busy, done, avm_read);
                end
                if (done && !done_prev) begin
                    if (exp_idx >= exp_q.size()) begin
                        cmp_n++;
                        cmp_fail++;
                        $display("FAIL unexpected_done: got done=1 required no completion");
                        have_cur = 1'b0;
                    end else begin
                        cur      = exp_q[exp_idx];
                        exp_idx  = exp_idx + 1;
                        have_cur = 1'b1;
                    end
                end
                if (done && have_cur) begin
                    cmp_n++;
                    if (act !== cur) begin
                        cmp_fail++;
                        $display("FAIL outcome: got %h required %h", act, cur);
                    end
                end
                if (!done) begin
                    cmp_n++;
                    if ({pass, err_timeout, err_id, err_ts} != 4'b0) begin
                        cmp_fail++;
                        $display("FAIL flags_while_running: got %b required 0000",
                                 {pass, err_timeout, err_id, err_ts});
                    end
                end
                done_prev = done;
            end
        end
    end

    // ---------------- driver tasks ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // called on a negedge while done; returns on the first sample of the new scan
    task automatic do_rescan();
        rescan = 1'b1;
        @(negedge clock);
        rescan = 1'b0;
    endtask

    // sample index 0 is the current negedge
    task automatic wait_scan(input int bound, output int busy_at, output int done_at);
        busy_at = -1;
        done_at = -1;
        for (int n = 0; n <= bound; n++) begin
            if (busy && busy_at < 0) busy_at = n;
            if (done) begin
                done_at = n;
                break;
            end
            @(negedge clock);
        end
        chk("scan_completes", {31'd0, done}, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int b_at, d_at;
        int hi0, hi1, ac0, ac1;

        // reset state and zero-wait auto-start
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_read", {31'd0, avm_read}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        push_expect();
        reset = 1'b0;
        wait_scan(40, b_at, d_at);
        chk("idle_one_cycle", b_at, 1);
        chk("zero_wait_latency", d_at - b_at, 3);
        chk("zero_wait_pass", {31'd0, pass}, 32'd1);

        // timestamp mismatch, rescan in DONE, rescan while busy
        cfg_ts = 32'h1234_5678;
        push_expect();
        do_rescan();
        chk("rescan_done_drops", {31'd0, done}, 32'd0);
        chk("rescan_busy", {31'd0, busy}, 32'd1);
        chk("rescan_read", {31'd0, avm_read}, 32'd1);
        chk("rescan_addr", {31'd0, avm_address}, 32'd0);
        rescan = 1'b1;
        @(negedge clock);
        rescan = 1'b0;
        wait_scan(40, b_at, d_at);
        chk("mismatch_pass", {31'd0, pass}, 32'd0);
        chk("mismatch_err_ts", {31'd0, err_ts}, 32'd1);
        chk("mismatch_err_id", {31'd0, err_id}, 32'd0);
        chk("mismatch_ts_value", ts_value, 32'h1234_5678);
        repeat (5) begin
            @(negedge clock);
            chk("busy_rescan_not_queued", {30'd0, done, busy}, 32'd2);
        end

        // waitrequest 5 cycles, readdatavalid 3 cycles after accept
        cfg_ts  = EXP_TS;
        cfg_ws  = 5;
        cfg_lat = 3;
        push_expect();
        hi0 = rd_hi[0];
        hi1 = rd_hi[1];
        do_rescan();
        wait_scan(80, b_at, d_at);
        chk("stall_read_cycles_id", rd_hi[0] - hi0, 6);
        chk("stall_read_cycles_ts", rd_hi[1] - hi1, 6);
        chk("stall_pass", {31'd0, pass}, 32'd1);

        // slave never returns data: retries then timeout failure
        cfg_ws   = 0;
        cfg_lat  = 0;
        cfg_mute = 1'b1;
        push_expect();
        ac0 = accept[0];
        ac1 = accept[1];
        do_rescan();
        wait_scan(200, b_at, d_at);
        chk("timeout_id_issues", accept[0] - ac0, RETRIES + 1);
        chk("timeout_ts_issues", accept[1] - ac1, 0);
        chk("timeout_duration", d_at - b_at, (RETRIES + 1) * (TMO + 1));
        chk("timeout_flag", {31'd0, err_timeout}, 32'd1);
        chk("timeout_done", {31'd0, done}, 32'd1);
        cfg_mute = 1'b0;

        // randomized slave timing and data
        for (int i = 0; i < 12; i++) begin
            cfg_ws  = $urandom_range(0, 6);
            cfg_lat = $urandom_range(0, 6);
            cfg_id  = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
            cfg_ts  = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
            push_expect();
            hi0 = rd_hi[0];
            hi1 = rd_hi[1];
            do_rescan();
            wait_scan(80, b_at, d_at);
            chk("rand_read_cycles_id", rd_hi[0] - hi0, cfg_ws + 1);
            chk("rand_read_cycles_ts", rd_hi[1] - hi1, cfg_ws + 1);
        end

        // reset while waiting for the timestamp, spurious strobe after release
        cfg_id  = EXP_ID;
        cfg_ts  = EXP_TS;
        cfg_ws  = 0;
        cfg_lat = 10;
        do_rescan();
        for (int n = 0; n < 30; n++) begin
            if (avm_address && !avm_read && busy) break;
            @(negedge clock);
        end
        chk("reached_ts_wait", {30'd0, avm_address, avm_read}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_read", {31'd0, avm_read}, 32'd0);
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_done", {31'd0, done}, 32'd0);
        m_last_id = '0;
        m_last_ts = '0;
        cfg_lat   = 0;
        spur_en   = 1'b1;
        push_expect();
        @(posedge clock);
        @(negedge clock);
        reset   = 1'b0;
        spur_en = 1'b0;
        wait_scan(40, b_at, d_at);
        chk("post_reset_pass", {31'd0, pass}, 32'd1);
        chk("post_reset_id_value", id_value, 32'd0);

        repeat (3) @(negedge clock);
        chk("all_expectations_consumed", exp_idx, exp_q.size());

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert + cmp_n, n_fail + cmp_fail);
        $finish;
    end

endmodule
